// File: rtl/l15_mem_responder_if.sv
// L1.5 request/return bundle between the core (master) and a memory responder (slave).
interface l15_mem_responder_if;
  logic         req_val_i;
  logic [4:0]   req_rqtype_i;
  logic [2:0]   req_size_i;
  logic [39:0]  req_address_i;
  logic [63:0]  req_data_i;
  logic         req_threadid_i;
  logic         req_header_ack_o;
  logic         req_ack_o;
  logic         rtrn_val_o;
  logic [3:0]   rtrn_returntype_o;
  logic         rtrn_threadid_o;
  logic [255:0] rtrn_data_o;
  logic         rtrn_ack_i;

  modport master (
    output req_val_i, req_rqtype_i, req_size_i, req_address_i, req_data_i,
           req_threadid_i, rtrn_ack_i,
    input  req_header_ack_o, req_ack_o, rtrn_val_o, rtrn_returntype_o,
           rtrn_threadid_o, rtrn_data_o
  );

  modport slave (
    input  req_val_i, req_rqtype_i, req_size_i, req_address_i, req_data_i,
           req_threadid_i, rtrn_ack_i,
    output req_header_ack_o, req_ack_o, rtrn_val_o, rtrn_returntype_o,
           rtrn_threadid_o, rtrn_data_o
  );
endinterface

// File: rtl/l15_mem_responder.sv
// Single-outstanding L1.5 memory responder: load/store/ifill from a 64-bit word
// memory, returning the response a fixed number of cycles after accept.
module l15_mem_responder #(
  parameter int AddrWidthWords = 10,
  parameter int MemLatency     = 2,
  parameter bit SwapEndianess  = 1'b1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  l15_mem_responder_if.slave l15,
  output logic               busy_o
);
  localparam int AW = AddrWidthWords;

  localparam logic [4:0] RQ_LOAD  = 5'b00000;
  localparam logic [4:0] RQ_STORE = 5'b00001;
  localparam logic [4:0] RQ_IMISS = 5'b10000;

  localparam logic [3:0] RT_LOAD  = 4'h0;
  localparam logic [3:0] RT_IFILL = 4'h1;
  localparam logic [3:0] RT_STACK = 4'h4;
  localparam logic [3:0] RT_ERR   = 4'hF;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e         state_q, state_d;
  logic [7:0]     cnt_q;
  logic [3:0]     rt_q;
  logic           tid_q;
  logic [AW-1:0]  idx_q;
  logic [255:0]   data_q;
  logic [63:0]    mem [0:(1<<AW)-1];

  logic           accept, wr_en, load_rd;
  logic [3:0]     in_rt, cur_rt;
  logic [2:0]     mask;
  logic [7:0]     be_base, in_be;
  logic [AW-1:0]  in_idx, cur_idx;
  logic [AW-3:0]  line;
  logic [63:0]    wdata;
  logic [255:0]   rd_data;
  logic           unused_addr;

  function automatic logic [63:0] swp(input logic [63:0] w);
    logic [63:0] r;
    r = w;
    if (SwapEndianess)
      for (int i = 0; i < 8; i++) r[8*i +: 8] = w[8*(7-i) +: 8];
    return r;
  endfunction

  assign in_idx      = l15.req_address_i[3 +: AW];
  assign unused_addr = ^l15.req_address_i[39:3+AW];
  assign wdata       = swp(l15.req_data_i);
  assign accept      = (state_q == IDLE) && l15.req_val_i && !rst_i;
  assign wr_en       = accept && (in_rt == RT_STACK);

  // Classify the incoming request into its return type (errors included) and byte lanes
  always_comb begin
    mask    = 3'b000;
    be_base = 8'h01;
    in_rt   = RT_ERR;
    case (l15.req_size_i)
      3'd1:    begin mask = 3'b001; be_base = 8'h03; end
      3'd2:    begin mask = 3'b011; be_base = 8'h0F; end
      3'd3:    begin mask = 3'b111; be_base = 8'hFF; end
      default: begin mask = 3'b000; be_base = 8'h01; end
    endcase
    in_be = be_base << l15.req_address_i[2:0];
    case (l15.req_rqtype_i)
      RQ_LOAD:  if (l15.req_size_i <= 3'd3 && (l15.req_address_i[2:0] & mask) == 3'b000)
                  in_rt = RT_LOAD;
      RQ_STORE: if (l15.req_size_i <= 3'd3 && (l15.req_address_i[2:0] & mask) == 3'b000)
                  in_rt = RT_STACK;
      RQ_IMISS: in_rt = RT_IFILL;
      default:  in_rt = RT_ERR;
    endcase
  end

  // Read mux: with zero latency the data is taken in the accept cycle from the live request
  always_comb begin
    cur_rt  = (state_q == IDLE) ? in_rt  : rt_q;
    cur_idx = (state_q == IDLE) ? in_idx : idx_q;
    line    = cur_idx[AW-1:2];
    rd_data = '0;
    case (cur_rt)
      RT_LOAD:  rd_data = {128'b0, swp(mem[cur_idx]), swp(mem[cur_idx])};
      RT_IFILL: rd_data = {swp(mem[{line, 2'd3}]), swp(mem[{line, 2'd2}]),
                           swp(mem[{line, 2'd1}]), swp(mem[{line, 2'd0}])};
      default:  rd_data = '0;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (MemLatency == 0) ? RESP : WAIT;
      WAIT:    if (cnt_q <= 8'd1) state_d = RESP;
      RESP:    if (l15.rtrn_ack_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign load_rd = (state_d == RESP) && (state_q != RESP);

  // State, request capture, latency counter and return data register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rt_q    <= '0;
      tid_q   <= 1'b0;
      idx_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q <= 8'(MemLatency);
        rt_q  <= in_rt;
        tid_q <= l15.req_threadid_i;
        idx_q <= in_idx;
      end else if (state_q == WAIT) begin
        cnt_q <= cnt_q - 8'd1;
      end
      if (load_rd) data_q <= rd_data;
    end
  end

  // Store byte lanes at the accept edge; memory itself is never reset
  always_ff @(posedge clk_i) begin
    if (wr_en)
      for (int i = 0; i < 8; i++)
        if (in_be[i]) mem[in_idx][8*i +: 8] <= wdata[8*i +: 8];
  end

  assign l15.req_header_ack_o  = accept;
  assign l15.req_ack_o         = accept;
  assign l15.rtrn_val_o        = (state_q == RESP);
  assign l15.rtrn_returntype_o = rt_q;
  assign l15.rtrn_threadid_o   = tid_q;
  assign l15.rtrn_data_o       = data_q;
  assign busy_o                = (state_q != IDLE);
endmodule
